// File: rtl/sfq_readout_pkg.sv
// Shared types and default sizing for the SFQ/DC readout block.
package sfq_readout_pkg;

    // Frame sequencer states: idle, or counting pulses within a frame
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_e;

    // Default bits per lane counter
    localparam int CNT_W_DEFAULT     = 8;
    // Default clock cycles per counting frame
    localparam int FRAME_LEN_DEFAULT = 16;

endpackage

// File: rtl/sfq_readout_fifo.sv
// Two-entry output FIFO holding completed frames. The head entry is shown
// combinationally and reads as zero when the FIFO is empty. A push into a
// full FIFO is accepted only if a pop happens in the same cycle.
module sfq_readout_fifo
    import sfq_readout_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          C,
    input  logic          R,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign do_pop  = pop && !empty;
    // When full, the slot being popped this cycle is the one written next
    assign do_push = push && (!full || do_pop);

    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
        end
    end

    // FIFO state registers, cleared immediately on reset
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sfq_dc_readout.sv
// SFQ pulse readout: per-lane SFQ/DC toggle outputs plus framed pulse
// counting. Each frame's saturating lane counts and a saturation flag are
// handed to a consumer through a 2-entry valid/ready FIFO; frames arriving
// when the FIFO cannot accept them are dropped and flagged in sticky OVF.
module sfq_dc_readout
    import sfq_readout_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int CNT_W     = CNT_W_DEFAULT,
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT
) (
    input  logic                   C,
    input  logic                   R,
    input  logic [WIDTH-1:0]       A,
    input  logic                   EN,
    output logic [WIDTH-1:0]       Q_DC,
    output logic [WIDTH*CNT_W-1:0] CNT_DATA,
    output logic                   CNT_VALID,
    input  logic                   CNT_READY,
    output logic                   OVF,
    output logic                   SAT,
    output logic                   BUSY
);

    localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int DW   = WIDTH * CNT_W + 1;
    localparam logic [FC_W-1:0]  LAST_POS = FC_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e                 state_q, state_d;
    logic [FC_W-1:0]        frame_cnt_q, frame_cnt_d;
    logic                   sat_q, sat_d;
    logic                   ovf_q, ovf_d;
    logic [WIDTH-1:0]       qdc_q, qdc_d;

    logic                   counting;
    logic                   last_cycle;
    logic [WIDTH-1:0]       lane_clip;
    logic [WIDTH*CNT_W-1:0] frame_counts;
    logic                   frame_sat;
    logic                   push, pop;
    logic                   fifo_full, fifo_empty;
    logic [DW-1:0]          fifo_head;

    assign counting   = (state_q == S_COUNT);
    assign last_cycle = counting && (frame_cnt_q == LAST_POS);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sum;

            // A pulse arriving at full scale is clipped, which marks the frame saturated
            assign lane_clip[gi] = A[gi] && (cnt_q == CNT_MAX);
            assign cnt_sum       = lane_clip[gi] ? cnt_q : cnt_q + CNT_W'(A[gi]);
            // The pushed frame includes this cycle's pulse
            assign frame_counts[gi*CNT_W +: CNT_W] = cnt_sum;

            // Accumulate during COUNT; restart from zero after the last frame cycle
            always_comb begin
                cnt_d = cnt_q;
                if (counting) begin
                    cnt_d = last_cycle ? '0 : cnt_sum;
                end
            end

            // Lane counter register
            always_ff @(posedge C or posedge R) begin
                if (R) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign frame_sat = sat_q | (|lane_clip);
    assign push      = last_cycle;
    assign pop       = !fifo_empty && CNT_READY;

    // Frame sequencer: enter COUNT on EN, leave only at a frame boundary
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        sat_d       = sat_q;
        case (state_q)
            S_IDLE: begin
                frame_cnt_d = '0;
                sat_d       = 1'b0;
                if (EN) begin
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (last_cycle) begin
                    frame_cnt_d = '0;
                    sat_d       = 1'b0;
                    if (!EN) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q + FC_W'(1);
                    sat_d       = frame_sat;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // SFQ/DC toggles on every pulse; overflow latches when a frame is lost
    always_comb begin
        qdc_d = qdc_q ^ A;
        ovf_d = ovf_q | (push && fifo_full && !pop);
    end

    // Control registers
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= '0;
            sat_q       <= 1'b0;
            ovf_q       <= 1'b0;
            qdc_q       <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            sat_q       <= sat_d;
            ovf_q       <= ovf_d;
            qdc_q       <= qdc_d;
        end
    end

    sfq_readout_fifo #(
        .DW(DW)
    ) u_fifo (
        .C         (C),
        .R         (R),
        .push      (push),
        .push_data ({frame_sat, frame_counts}),
        .pop       (pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign Q_DC      = qdc_q;
    assign CNT_DATA  = fifo_head[WIDTH*CNT_W-1:0];
    assign SAT       = fifo_head[DW-1];
    assign CNT_VALID = !fifo_empty;
    assign OVF       = ovf_q;
    assign BUSY      = (state_q == S_COUNT);

endmodule

// File: tb/tb_sfq_dc_readout.sv
// Bench for sfq_dc_readout: directed scenarios plus a randomized run checked
// against a frame-level model (pulse sums per frame, a bounded queue of frames).
module tb_sfq_dc_readout;

    localparam int FRAME_LEN = 16;

    logic        C = 1'b0;
    logic        R;
    logic [3:0]  A;
    logic        EN;
    logic        CNT_READY;

    logic [3:0]  Q_DC, Q_DC_S;
    logic [31:0] CNT_DATA;
    logic [15:0] CNT_DATA_S;
    logic        CNT_VALID, CNT_VALID_S;
    logic        OVF, OVF_S;
    logic        SAT, SAT_S;
    logic        BUSY, BUSY_S;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: raw pulse sums per lane (16 bits each), queue of completed frames
    bit          m_busy;
    int          m_pos;
    logic [63:0] m_sum;
    logic [63:0] m_q[$];
    bit          m_ovf;
    logic [3:0]  m_qdc;

    always #5 C = ~C;

    sfq_dc_readout #(.WIDTH(4), .CNT_W(8), .FRAME_LEN(FRAME_LEN)) u_dut (
        .C(C), .R(R), .A(A), .EN(EN), .Q_DC(Q_DC), .CNT_DATA(CNT_DATA),
        .CNT_VALID(CNT_VALID), .CNT_READY(CNT_READY), .OVF(OVF), .SAT(SAT), .BUSY(BUSY)
    );

    sfq_dc_readout #(.WIDTH(4), .CNT_W(4), .FRAME_LEN(FRAME_LEN)) u_sat (
        .C(C), .R(R), .A(A), .EN(EN), .Q_DC(Q_DC_S), .CNT_DATA(CNT_DATA_S),
        .CNT_VALID(CNT_VALID_S), .CNT_READY(CNT_READY), .OVF(OVF_S), .SAT(SAT_S), .BUSY(BUSY_S)
    );

    function automatic logic [31:0] exp8(input logic [63:0] s);
        logic [31:0] d;
        for (int i = 0; i < 4; i++) d[i*8 +: 8] = (s[i*16 +: 16] > 16'd255) ? 8'd255 : s[i*16 +: 8];
        return d;
    endfunction

    function automatic logic [15:0] exp4(input logic [63:0] s);
        logic [15:0] d;
        for (int i = 0; i < 4; i++) d[i*4 +: 4] = (s[i*16 +: 16] > 16'd15) ? 4'd15 : s[i*16 +: 4];
        return d;
    endfunction

    function automatic logic exps(input logic [63:0] s, input int maxv);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) if (int'(s[i*16 +: 16]) > maxv) r = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_pos = 0; m_sum = '0; m_q.delete(); m_ovf = 0; m_qdc = '0;
    endtask

    // Drive one cycle of inputs, advance the model, step past the clock edge
    task automatic cyc(input logic [3:0] a, input logic en, input logic rdy);
        bit          pop;
        bit          do_push;
        logic [63:0] frame;
        A = a; EN = en; CNT_READY = rdy;
        do_push = 0;
        frame   = '0;
        pop     = (m_q.size() > 0) && rdy;
        m_qdc   = m_qdc ^ a;
        if (m_busy) begin
            for (int i = 0; i < 4; i++) m_sum[i*16 +: 16] = m_sum[i*16 +: 16] + 16'(a[i]);
            if (m_pos == FRAME_LEN - 1) begin
                frame = m_sum; do_push = 1; m_sum = '0; m_pos = 0; m_busy = en;
            end else begin
                m_pos++;
            end
        end else if (en) begin
            m_busy = 1; m_pos = 0;
        end
        if (pop) void'(m_q.pop_front());
        if (do_push) begin
            if (m_q.size() < 2) m_q.push_back(frame);
            else m_ovf = 1;
        end
        @(posedge C); #1;
    endtask

    task automatic do_reset();
        R = 1'b1; #2; R = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        A = 4'hF; EN = 1'b1; CNT_READY = 1'b0;
        #1 R = 1'b1;
        repeat (3) @(posedge C);
        #1;
        n_checks++; if (Q_DC !== 4'h0) $display("FAIL reset_qdc: got %h want 0", Q_DC); else n_pass++;
        n_checks++; if (CNT_DATA !== 32'h0) $display("FAIL reset_data: got %h want 0", CNT_DATA); else n_pass++;
        n_checks++; if (CNT_VALID !== 1'b0) $display("FAIL reset_valid: got %b want 0", CNT_VALID); else n_pass++;
        n_checks++; if (OVF !== 1'b0) $display("FAIL reset_ovf: got %b want 0", OVF); else n_pass++;
        n_checks++; if (SAT !== 1'b0) $display("FAIL reset_sat: got %b want 0", SAT); else n_pass++;
        n_checks++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY); else n_pass++;
        n_checks++; if ({Q_DC_S, CNT_DATA_S, CNT_VALID_S, OVF_S, SAT_S, BUSY_S} !== 24'h0)
            $display("FAIL reset_sat_inst: got %h want 0", {Q_DC_S, CNT_DATA_S, CNT_VALID_S, OVF_S, SAT_S, BUSY_S}); else n_pass++;
        R = 1'b0; A = 4'h0; EN = 1'b0;
        model_reset();
        $display("test_reset done");
    endtask

    task automatic test_count();
        do_reset();
        cyc(4'b0000, 1'b1, 1'b1);
        for (int p = 0; p < FRAME_LEN; p++) begin
            cyc(4'b0001, p < FRAME_LEN - 1, 1'b1);
            if (p == FRAME_LEN - 2) begin
                n_checks++; if (CNT_VALID !== 1'b0) $display("FAIL count_early_valid: got %b want 0", CNT_VALID); else n_pass++;
            end
        end
        n_checks++; if (CNT_VALID !== 1'b1) $display("FAIL count_valid: got %b want 1", CNT_VALID); else n_pass++;
        n_checks++; if (CNT_DATA !== 32'h0000_0010) $display("FAIL count_data: got %h want 00000010", CNT_DATA); else n_pass++;
        n_checks++; if (SAT !== 1'b0) $display("FAIL count_sat: got %b want 0", SAT); else n_pass++;
        n_checks++; if (Q_DC !== 4'b0000) $display("FAIL count_qdc: got %b want 0000", Q_DC); else n_pass++;
        n_checks++; if (BUSY !== 1'b0) $display("FAIL count_busy: got %b want 0", BUSY); else n_pass++;
        n_checks++; if (CNT_DATA_S !== 16'h000F || SAT_S !== 1'b1)
            $display("FAIL count_sat_inst: got %h/%b want 000f/1", CNT_DATA_S, SAT_S); else n_pass++;
        cyc(4'b0000, 1'b0, 1'b1);
        n_checks++; if (CNT_VALID !== 1'b0) $display("FAIL count_pop: got valid %b want 0", CNT_VALID); else n_pass++;
        $display("test_count done");
    endtask

    task automatic test_saturation();
        do_reset();
        cyc(4'b0000, 1'b1, 1'b1);
        for (int p = 0; p < FRAME_LEN; p++) cyc(4'b0010, p < FRAME_LEN - 1, 1'b1);
        n_checks++; if (CNT_VALID_S !== 1'b1) $display("FAIL sat_valid: got %b want 1", CNT_VALID_S); else n_pass++;
        n_checks++; if (CNT_DATA_S !== 16'h00F0) $display("FAIL sat_data: got %h want 00f0", CNT_DATA_S); else n_pass++;
        n_checks++; if (SAT_S !== 1'b1) $display("FAIL sat_flag: got %b want 1", SAT_S); else n_pass++;
        n_checks++; if (CNT_DATA !== 32'h0000_1000 || SAT !== 1'b0)
            $display("FAIL sat_wide_inst: got %h/%b want 00001000/0", CNT_DATA, SAT); else n_pass++;
        cyc(4'b0000, 1'b0, 1'b1);
        $display("test_saturation done");
    endtask

    task automatic test_overflow();
        do_reset();
        cyc(4'b0000, 1'b1, 1'b0);
        for (int f = 1; f <= 3; f++) begin
            for (int p = 0; p < FRAME_LEN; p++)
                cyc((p < f) ? 4'b0001 : 4'b0000, !(f == 3 && p == FRAME_LEN - 1), 1'b0);
            if (f == 2) begin
                n_checks++; if (OVF !== 1'b0) $display("FAIL ovf_early: got %b want 0", OVF); else n_pass++;
            end
        end
        n_checks++; if (OVF !== 1'b1) $display("FAIL ovf_set: got %b want 1", OVF); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (CNT_VALID !== 1'b1 || CNT_DATA !== 32'h1)
                $display("FAIL ovf_hold: got %b/%h want 1/00000001", CNT_VALID, CNT_DATA); else n_pass++;
            cyc(4'b0000, 1'b0, 1'b0);
        end
        cyc(4'b0000, 1'b0, 1'b1);
        n_checks++; if (CNT_VALID !== 1'b1 || CNT_DATA !== 32'h2)
            $display("FAIL ovf_second: got %b/%h want 1/00000002", CNT_VALID, CNT_DATA); else n_pass++;
        cyc(4'b0000, 1'b0, 1'b1);
        n_checks++; if (CNT_VALID !== 1'b0) $display("FAIL ovf_drained: got %b want 0", CNT_VALID); else n_pass++;
        n_checks++; if (OVF !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", OVF); else n_pass++;
        $display("test_overflow done");
    endtask

    task automatic test_full_push_pop();
        do_reset();
        cyc(4'b0000, 1'b1, 1'b0);
        for (int f = 1; f <= 3; f++)
            for (int p = 0; p < FRAME_LEN; p++)
                cyc((p < f) ? 4'b1000 : 4'b0000, !(f == 3 && p == FRAME_LEN - 1), f == 3 && p == FRAME_LEN - 1);
        n_checks++; if (OVF !== 1'b0) $display("FAIL fpp_ovf: got %b want 0", OVF); else n_pass++;
        n_checks++; if (CNT_DATA !== 32'h0200_0000) $display("FAIL fpp_head: got %h want 02000000", CNT_DATA); else n_pass++;
        cyc(4'b0000, 1'b0, 1'b1);
        n_checks++; if (CNT_VALID !== 1'b1 || CNT_DATA !== 32'h0300_0000)
            $display("FAIL fpp_kept: got %b/%h want 1/03000000", CNT_VALID, CNT_DATA); else n_pass++;
        cyc(4'b0000, 1'b0, 1'b1);
        n_checks++; if (CNT_VALID !== 1'b0) $display("FAIL fpp_drained: got %b want 0", CNT_VALID); else n_pass++;
        $display("test_full_push_pop done");
    endtask

    task automatic test_en_fall();
        do_reset();
        cyc(4'b0000, 1'b1, 1'b0);
        for (int p = 0; p < FRAME_LEN; p++) begin
            cyc(4'b0100, p < 5, 1'b0);
            if (p >= 5 && p < FRAME_LEN - 1) begin
                n_checks++; if (BUSY !== 1'b1) $display("FAIL enfall_busy_p%0d: got %b want 1", p, BUSY); else n_pass++;
            end
        end
        n_checks++; if (BUSY !== 1'b0) $display("FAIL enfall_idle: got %b want 0", BUSY); else n_pass++;
        n_checks++; if (CNT_VALID !== 1'b1 || CNT_DATA !== 32'h0010_0000)
            $display("FAIL enfall_frame: got %b/%h want 1/00100000", CNT_VALID, CNT_DATA); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            cyc(4'b1111, 1'b0, 1'b0);
            n_checks++; if (Q_DC !== m_qdc) $display("FAIL idle_qdc: got %b want %b", Q_DC, m_qdc); else n_pass++;
            n_checks++; if (CNT_DATA !== 32'h0010_0000 || BUSY !== 1'b0)
                $display("FAIL idle_nocount: got %h/%b want 00100000/0", CNT_DATA, BUSY); else n_pass++;
        end
        cyc(4'b0000, 1'b0, 1'b1);
        $display("test_en_fall done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(4'b0000, 1'b1, 1'b0);
        for (int p = 0; p < FRAME_LEN + 7; p++) cyc(4'b0011, 1'b1, 1'b0);
        n_checks++; if (CNT_VALID !== 1'b1 || BUSY !== 1'b1 || Q_DC !== m_qdc)
            $display("FAIL rmid_pre: got %b/%b/%b want 1/1/%b", CNT_VALID, BUSY, Q_DC, m_qdc); else n_pass++;
        R = 1'b1; #2;
        n_checks++; if ({Q_DC, CNT_DATA, CNT_VALID, OVF, SAT, BUSY} !== 40'h0)
            $display("FAIL rmid_outputs: got %h want 0", {Q_DC, CNT_DATA, CNT_VALID, OVF, SAT, BUSY}); else n_pass++;
        R = 1'b0;
        model_reset();
        cyc(4'b0000, 1'b1, 1'b1);
        for (int p = 0; p < FRAME_LEN; p++) begin
            cyc(4'b1000, p < FRAME_LEN - 1, 1'b1);
            if (p == FRAME_LEN - 2) begin
                n_checks++; if (CNT_VALID !== 1'b0) $display("FAIL rmid_early: got %b want 0", CNT_VALID); else n_pass++;
            end
        end
        n_checks++; if (CNT_VALID !== 1'b1 || CNT_DATA !== 32'h1000_0000 || SAT !== 1'b0)
            $display("FAIL rmid_fresh: got %b/%h/%b want 1/10000000/0", CNT_VALID, CNT_DATA, SAT); else n_pass++;
        cyc(4'b0000, 1'b0, 1'b1);
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic       en, rdy;
        bit         v;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            a    = 4'($urandom);
            a[3] = ($urandom_range(0, 15) != 0);
            en   = ($urandom_range(0, 19) != 0);
            rdy  = (n < 400) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 24) == 0);
            cyc(a, en, rdy);
            v = (m_q.size() > 0);
            n_checks++; if (CNT_VALID !== v || CNT_VALID_S !== v)
                $display("FAIL rnd_valid c%0d: got %b/%b want %b", n, CNT_VALID, CNT_VALID_S, v); else n_pass++;
            n_checks++; if (OVF !== m_ovf || OVF_S !== m_ovf)
                $display("FAIL rnd_ovf c%0d: got %b/%b want %b", n, OVF, OVF_S, m_ovf); else n_pass++;
            n_checks++; if (BUSY !== m_busy || BUSY_S !== m_busy)
                $display("FAIL rnd_busy c%0d: got %b/%b want %b", n, BUSY, BUSY_S, m_busy); else n_pass++;
            n_checks++; if (Q_DC !== m_qdc || Q_DC_S !== m_qdc)
                $display("FAIL rnd_qdc c%0d: got %b/%b want %b", n, Q_DC, Q_DC_S, m_qdc); else n_pass++;
            if (v) begin
                n_checks++; if (CNT_DATA !== exp8(m_q[0]) || SAT !== exps(m_q[0], 255))
                    $display("FAIL rnd_data c%0d: got %h/%b want %h/%b", n, CNT_DATA, SAT, exp8(m_q[0]), exps(m_q[0], 255)); else n_pass++;
                n_checks++; if (CNT_DATA_S !== exp4(m_q[0]) || SAT_S !== exps(m_q[0], 15))
                    $display("FAIL rnd_data_s c%0d: got %h/%b want %h/%b", n, CNT_DATA_S, SAT_S, exp4(m_q[0]), exps(m_q[0], 15)); else n_pass++;
            end
        end
        $display("test_random done");
    endtask

    initial begin
        R = 1'b0; A = 4'h0; EN = 1'b0; CNT_READY = 1'b0;
        model_reset();
        test_reset();
        test_count();
        test_saturation();
        test_overflow();
        test_full_push_pop();
        test_en_fall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sfq_dc_readout.md
SFQ_DC_READOUT -- requirements
Module: sfq_dc_readout

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, 4: number of pulse lanes.
- CNT_W, 8: bits per lane counter.
- FRAME_LEN, 16: clock cycles per counting frame (2..256).
REQ-002 The block SHALL have these ports:
- C  input  1  system clock; all state changes on rising edge.
- R  input  1  reset, asynchronous, active-high.
- A  input  WIDTH  per-lane pulse-present flags, one sample per C cycle (from DFFT/NDROT outputs).
- EN  input  1  counting enable.
- Q_DC  output  WIDTH  SFQ/DC converter level, one per lane.
- CNT_DATA  output  WIDTH*CNT_W  frame counts; lane i at bits [i*CNT_W +: CNT_W].
- CNT_VALID  output  1  CNT_DATA holds an unconsumed frame.
- CNT_READY  input  1  consumer accepts the frame.
- OVF  output  1  sticky flag: a frame was dropped.
- SAT  output  1  the presented frame had at least one saturated lane.
- BUSY  output  1  FSM is not in IDLE.
REQ-003 Clock is C; reset is R, asynchronous and active-high. There is exactly one clock domain.

Function
REQ-004 Q_DC[i] SHALL toggle on every cycle where A[i]=1, in every FSM state.
REQ-005 The FSM SHALL have two states, IDLE and COUNT.
- IDLE->COUNT when EN=1.
- COUNT->IDLE at the last frame cycle when EN=0.
- Otherwise it stays in COUNT.
REQ-006 The frame counter SHALL run 0..FRAME_LEN-1 in COUNT and wrap to 0 at the last frame cycle.
REQ-007 The first frame cycle is the cycle in which the FSM is in COUNT with frame counter 0.
REQ-008 Each lane counter SHALL add A[i] on every COUNT cycle, including the first and last frame cycles.
REQ-009 A lane counter SHALL saturate at 2^CNT_W-1 and set that frame's SAT bit; it never wraps.
REQ-010 At the last frame cycle the block SHALL do all of the following:
- Push {counts including this cycle's pulses, SAT bit} into the output buffer.
- Clear the lane counters and SAT bit, so the next frame starts from 0.
REQ-011 Latency: a pushed frame SHALL appear on CNT_DATA/CNT_VALID on the cycle after the push when the buffer was empty.
REQ-012 The output buffer SHALL be a 2-entry FIFO. The head entry drives CNT_DATA and SAT.
REQ-013 Valid/ready rules:
- A pop happens when CNT_VALID=1 and CNT_READY=1.
- CNT_DATA and SAT SHALL stay stable while CNT_VALID=1 and CNT_READY=0.
REQ-014 Push into a full FIFO with no pop in the same cycle: the frame SHALL be dropped and OVF set to 1. OVF clears only on R.
REQ-015 Push and pop in the same cycle with the FIFO full: the push SHALL be accepted, with no drop and no OVF.
REQ-016 If EN falls mid-frame, the current frame SHALL complete and be pushed. Then the FSM returns to IDLE.
REQ-017 Pulses in IDLE SHALL NOT be counted. Q_DC still toggles in IDLE.
REQ-018 BUSY SHALL be 1 exactly when the FSM is in COUNT.

Reset
REQ-019 Asserting R SHALL immediately put the block in this state, even mid-frame:
- FSM in IDLE.
- Frame counter and lane counters at 0.
- FIFO empty; any partial frame is discarded.
REQ-020 While R is asserted, all outputs SHALL be 0: Q_DC, CNT_DATA, CNT_VALID, OVF, SAT and BUSY.

Structure
REQ-021 The package sfq_readout_pkg SHALL hold the FSM state enum and the default CNT_W and FRAME_LEN constants.
REQ-022 The FIFO SHALL be the sub-module sfq_readout_fifo, parameterised by data width, with C/R and push/pop/full/empty ports.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Count: WIDTH=4, FRAME_LEN=16; EN=1, A=4'b0001 on all 16 cycles, CNT_READY=1. Expect lane0=16, others 0, CNT_VALID one cycle after the last frame cycle, SAT=0, Q_DC[0] back at 0.
- Saturation: CNT_W=4, A[1]=1 for the full 16-cycle frame. Expect lane1=15 and SAT=1.
- Overflow: CNT_READY=0 for 3 frames. Expect frames 1 and 2 held, frame 3 dropped, OVF=1. Then CNT_READY=1 pops frame 1 then frame 2 with unchanged data.
- Full push with pop: FIFO full, CNT_READY=1 on a last frame cycle. Expect the new frame kept and OVF=0.
- EN falls mid-frame: EN=0 at frame cycle 5. Expect the frame to complete, be pushed, then BUSY=0. Pulses in IDLE change Q_DC only.
- Reset mid-frame: R at frame cycle 7 with 1 entry buffered. Expect all outputs 0 immediately. After release, a new frame counts from 0.
